// File: rtl/mav_pkg.sv
// Shared types and constants for the moving-average controller and its ALU.
package mav_pkg;

  localparam int unsigned CNT_W = 2;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_SUB   = 3'd2,
    S_SHIFT = 3'd3,
    S_OUT   = 3'd4
  } mav_state_t;

endpackage

// File: rtl/mav_ctrl_cnt.sv
// Saturating count of completed samples, used to select raw output during warm-up.
module handshake_cnt
  import mav_pkg::*;
#(
  parameter int unsigned SAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT);

  logic [CNT_W-1:0] r_cnt;

  // Count up on each completed sample, hold at SAT; clr has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != SAT_V)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/mav_ctrl.sv
// Sequencer for the moving-average datapath: accept, add, subtract, shift, present.
module mav_ctrl
  import mav_pkg::*;
#(
  parameter int unsigned CNT_RAW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       en_din,
  output logic       en_sum3,
  output logic       en_mis,
  output logic       en_ans,
  output logic       sel_ans,
  output logic       sel_alu_b,
  output logic [2:0] f,
  output logic       clr_dp
);

  mav_state_t       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_en_sum3;
  logic             r_en_mis;
  logic             r_en_ans;
  logic             r_sel_ans;
  logic             r_sel_alu_b;
  logic [2:0]       r_f;
  logic [CNT_W-1:0] w_cnt;
  logic             w_raw;

  // Warm-up samples bypass averaging; cnt is stable from accept through ADD.
  assign w_raw = (w_cnt < CNT_W'(CNT_RAW));

  handshake_cnt #(
    .SAT (CNT_RAW)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (en_mis),
    .cnt (w_cnt)
  );

  // State register with outputs registered for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_en_sum3   <= 1'b0;
      r_en_mis    <= 1'b0;
      r_en_ans    <= 1'b0;
      r_sel_ans   <= 1'b0;
      r_sel_alu_b <= 1'b0;
      r_f         <= F_ADD;
    end else begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_en_sum3   <= 1'b0;
      r_en_mis    <= 1'b0;
      r_en_ans    <= 1'b0;
      r_sel_ans   <= 1'b0;
      r_sel_alu_b <= 1'b0;
      r_f         <= F_ADD;
      if (clr) begin
        r_state    <= S_IDLE;
        r_in_ready <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_valid) begin
              r_state   <= S_ADD;
              r_en_sum3 <= 1'b1;
              r_en_ans  <= 1'b1;
              r_sel_ans <= w_raw;
            end else begin
              r_in_ready <= 1'b1;
            end
          end
          S_ADD: begin
            r_state     <= S_SUB;
            r_en_sum3   <= 1'b1;
            r_sel_alu_b <= 1'b1;
            r_f         <= F_SUB;
          end
          S_SUB: begin
            r_state  <= S_SHIFT;
            r_en_mis <= 1'b1;
          end
          S_SHIFT: begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
          end
          S_OUT: begin
            if (out_ready) begin
              r_state    <= S_IDLE;
              r_in_ready <= 1'b1;
            end else begin
              r_out_valid <= 1'b1;
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  // clr suppresses every enable and the handshakes in the cycle it is seen.
  assign clr_dp    = clr;
  assign in_ready  = r_in_ready & ~clr;
  assign en_din    = in_ready & in_valid;
  assign out_valid = r_out_valid & ~clr;
  assign en_sum3   = r_en_sum3 & ~clr;
  assign en_mis    = r_en_mis & ~clr;
  assign en_ans    = r_en_ans & ~clr;
  assign sel_ans   = r_sel_ans;
  assign sel_alu_b = r_sel_alu_b;
  assign f         = r_f;

endmodule
